// File: rtl/counter_bus_sequencer.sv
// counter_bus_sequencer: bus-side sequencer for one 8254 counter (control word decode, CR byte loading, latch and read ordering)
// Ports:
//   global_CLK, CR_reset (async, active-high)
//   CS, WR, RD (active-low strobes), A[1:0] bus address, control_word[7:0] data byte on writes
//   count_loaded: CE has taken the CR value
//   CR_enable[1:0], load_new_count, status_register_enable, status_latch_enable: one-cycle pulses
//   OL_enable[1:0], out_count_enable[1:0], out_status_enable: levels
//   null_count, count_inhibit, rw_mode[1:0]: state
// Build option: COUNTER_READBACK_EN enables the [7:6]=11 read-back command.
module counter_bus_sequencer #(
  parameter logic [1:0] COUNTER_ID = 2'd0
) (
  input  logic       global_CLK,
  input  logic       CR_reset,
  input  logic       CS,
  input  logic       WR,
  input  logic       RD,
  input  logic [1:0] A,
  input  logic [7:0] control_word,
  input  logic       count_loaded,
  output logic [1:0] CR_enable,
  output logic       load_new_count,
  output logic [1:0] OL_enable,
  output logic       status_register_enable,
  output logic       status_latch_enable,
  output logic [1:0] out_count_enable,
  output logic       out_status_enable,
  output logic       null_count,
  output logic       count_inhibit,
  output logic [1:0] rw_mode
);
  logic       wr_prev, rd_prev, wr_ptr, rd_ptr, count_latched, status_latched;
  logic       wr_ev, rd_done, cw_hit, rd_q, nc_set;
  logic [1:0] rw_n, cre_n;
  logic       wp_n, rp_n, cl_n, sl_n, ci_n, lnc_n, sre_n, sle_n, nc_n;
  always_comb begin
    wr_ev  = wr_prev & ~WR & ~CS;
    rd_done = ~rd_prev & RD & ~CS & (A == COUNTER_ID);
    cw_hit = wr_ev && A == 2'b11 && control_word[7:6] == COUNTER_ID;
    rw_n   = rw_mode;
    wp_n   = wr_ptr;
    rp_n   = rd_ptr;
    cl_n   = count_latched;
    sl_n   = status_latched;
    ci_n   = count_inhibit;
    cre_n  = 2'b00;
    lnc_n  = 1'b0;
    sre_n  = 1'b0;
    sle_n  = 1'b0;
    nc_set = 1'b0;
    if (cw_hit && control_word[5:4] != 2'b00) begin
      rw_n   = control_word[5:4];
      sre_n  = 1'b1;
      wp_n   = 1'b0;
      rp_n   = 1'b0;
      cl_n   = 1'b0;
      sl_n   = 1'b0;
      ci_n   = 1'b0;
      nc_set = 1'b1;
    end else if (cw_hit) begin
      cl_n = 1'b1;
`ifdef COUNTER_READBACK_EN
    end else if (wr_ev && A == 2'b11 && control_word[7:6] == 2'b11 && control_word[1+COUNTER_ID]) begin
      if (!control_word[5]) cl_n = 1'b1;
      if (!control_word[4] && !status_latched) begin
        sl_n  = 1'b1;
        sle_n = 1'b1;
      end
`endif
    end else if (wr_ev && A == COUNTER_ID && rw_mode != 2'b00) begin
      if (rw_mode == 2'b11 && !wr_ptr) begin
        cre_n = 2'b01;
        ci_n  = 1'b1;
        wp_n  = 1'b1;
      end else begin
        cre_n = rw_mode == 2'b01 ? 2'b01 : 2'b10;
        lnc_n = 1'b1;
        ci_n  = 1'b0;
        wp_n  = 1'b0;
      end
    end else if (rd_done && !wr_ev) begin
      if (status_latched) sl_n = 1'b0;
      else if (rw_mode != 2'b00) begin
        if (rw_mode == 2'b11) rp_n = ~rd_ptr;
        if (rw_mode != 2'b11 || rd_ptr) cl_n = 1'b0;
      end
    end
    // a CR write (current or just issued) outranks a simultaneous CE load
    nc_n = (nc_set || cre_n != 2'b00 || CR_enable != 2'b00) ? 1'b1 : count_loaded ? 1'b0 : null_count;
  end
  always_ff @(posedge global_CLK or posedge CR_reset) begin
    if (CR_reset) begin
      wr_prev                <= 1'b1;
      rd_prev                <= 1'b1;
      wr_ptr                 <= 1'b0;
      rd_ptr                 <= 1'b0;
      count_latched          <= 1'b0;
      status_latched         <= 1'b0;
      rw_mode                <= 2'b00;
      count_inhibit          <= 1'b0;
      null_count             <= 1'b0;
      CR_enable              <= 2'b00;
      load_new_count         <= 1'b0;
      status_register_enable <= 1'b0;
      status_latch_enable    <= 1'b0;
    end else begin
      wr_prev                <= WR;
      rd_prev                <= RD;
      wr_ptr                 <= wp_n;
      rd_ptr                 <= rp_n;
      count_latched          <= cl_n;
      status_latched         <= sl_n;
      rw_mode                <= rw_n;
      count_inhibit          <= ci_n;
      null_count             <= nc_n;
      CR_enable              <= cre_n;
      load_new_count         <= lnc_n;
      status_register_enable <= sre_n;
      status_latch_enable    <= sle_n;
    end
  end
  // a simultaneous write wins the bus, so the read qualifier requires WR high
  assign rd_q              = ~CS & ~RD & WR & (A == COUNTER_ID);
  assign out_status_enable = rd_q & status_latched;
  assign out_count_enable  = (rd_q && !status_latched) ? (rw_mode == 2'b11 ? (rd_ptr ? 2'b10 : 2'b01) : rw_mode) : 2'b00;
  assign OL_enable         = count_latched ? 2'b00 : 2'b11;
endmodule

// File: tb/tb_counter_bus_sequencer.sv
// tb_counter_bus_sequencer: directed self-checking bench for counter_bus_sequencer (COUNTER_ID=0)
module tb_counter_bus_sequencer;
  logic       global_CLK, CR_reset, CS, WR, RD, count_loaded;
  logic [1:0] A;
  logic [7:0] control_word;
  logic [1:0] CR_enable, OL_enable, out_count_enable, rw_mode;
  logic       load_new_count, status_register_enable, status_latch_enable;
  logic       out_status_enable, null_count, count_inhibit;
  int errs = 0, checks = 0;
  logic [1:0] cre_s, oce_s;
  logic       lnc_s, sre_s, sle_s, ci_s, ose_s;

  counter_bus_sequencer #(.COUNTER_ID(2'd0)) dut (
    .global_CLK(global_CLK), .CR_reset(CR_reset), .CS(CS), .WR(WR), .RD(RD), .A(A),
    .control_word(control_word), .count_loaded(count_loaded), .CR_enable(CR_enable),
    .load_new_count(load_new_count), .OL_enable(OL_enable),
    .status_register_enable(status_register_enable), .status_latch_enable(status_latch_enable),
    .out_count_enable(out_count_enable), .out_status_enable(out_status_enable),
    .null_count(null_count), .count_inhibit(count_inhibit), .rw_mode(rw_mode));

  initial global_CLK = 1'b0;
  always #5 global_CLK = ~global_CLK;

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge global_CLK);
    CS = 1'b0; A = a; control_word = d; WR = 1'b0;
    @(posedge global_CLK); #1;
    cre_s = CR_enable; lnc_s = load_new_count; sre_s = status_register_enable;
    sle_s = status_latch_enable; ci_s = count_inhibit;
    @(negedge global_CLK);
    WR = 1'b1; CS = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    @(negedge global_CLK);
    CS = 1'b0; A = a; RD = 1'b0;
    #1;
    oce_s = out_count_enable; ose_s = out_status_enable;
    @(negedge global_CLK);
    RD = 1'b1;
    @(negedge global_CLK);
    CS = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge global_CLK);
    #1;
    checks++; if (rw_mode !== 2'b00) begin errs++; $display("FAIL reset_rw got %b exp 00", rw_mode); end
    checks++; if (OL_enable !== 2'b11) begin errs++; $display("FAIL reset_ol got %b exp 11", OL_enable); end
    checks++; if ({CR_enable, load_new_count, null_count, count_inhibit, out_count_enable, out_status_enable} !== 8'h00)
      begin errs++; $display("FAIL reset_outs got %b exp 0", {CR_enable, load_new_count, null_count, count_inhibit, out_count_enable, out_status_enable}); end
    @(negedge global_CLK); CR_reset = 1'b0;
  endtask

  task automatic test_control_word;
    wr(2'b11, 8'h30);
    checks++; if (sre_s !== 1'b1) begin errs++; $display("FAIL cw_sre got %b exp 1", sre_s); end
    checks++; if (rw_mode !== 2'b11) begin errs++; $display("FAIL cw_rw got %b exp 11", rw_mode); end
    checks++; if (null_count !== 1'b1) begin errs++; $display("FAIL cw_null got %b exp 1", null_count); end
    @(posedge global_CLK); #1;
    checks++; if (status_register_enable !== 1'b0) begin errs++; $display("FAIL cw_sre_pulse got %b exp 0", status_register_enable); end
  endtask

  task automatic test_rw11_load;
    wr(2'b00, 8'h34);
    checks++; if (cre_s !== 2'b01) begin errs++; $display("FAIL lsb_cre got %b exp 01", cre_s); end
    checks++; if ({ci_s, lnc_s} !== 2'b10) begin errs++; $display("FAIL lsb_ci_lnc got %b exp 10", {ci_s, lnc_s}); end
    checks++; if (count_inhibit !== 1'b1) begin errs++; $display("FAIL between_ci got %b exp 1", count_inhibit); end
    wr(2'b00, 8'h12);
    checks++; if (cre_s !== 2'b10) begin errs++; $display("FAIL msb_cre got %b exp 10", cre_s); end
    checks++; if ({ci_s, lnc_s} !== 2'b01) begin errs++; $display("FAIL msb_ci_lnc got %b exp 01", {ci_s, lnc_s}); end
    checks++; if (null_count !== 1'b1) begin errs++; $display("FAIL msb_null got %b exp 1", null_count); end
    @(negedge global_CLK); count_loaded = 1'b1;
    @(negedge global_CLK); count_loaded = 1'b0;
    checks++; if (null_count !== 1'b0) begin errs++; $display("FAIL loaded_null got %b exp 0", null_count); end
  endtask

  task automatic test_latch;
    wr(2'b11, 8'h00);
    checks++; if (OL_enable !== 2'b00) begin errs++; $display("FAIL latch_ol got %b exp 00", OL_enable); end
    checks++; if (rw_mode !== 2'b11) begin errs++; $display("FAIL latch_rw got %b exp 11", rw_mode); end
    wr(2'b11, 8'h00);
    rd(2'b00);
    checks++; if (oce_s !== 2'b01) begin errs++; $display("FAIL latch_rd1 got %b exp 01", oce_s); end
    checks++; if (OL_enable !== 2'b00) begin errs++; $display("FAIL latch_ol_mid got %b exp 00", OL_enable); end
    rd(2'b00);
    checks++; if (oce_s !== 2'b10) begin errs++; $display("FAIL latch_rd2 got %b exp 10", oce_s); end
    checks++; if (OL_enable !== 2'b11) begin errs++; $display("FAIL latch_ol_end got %b exp 11", OL_enable); end
    rd(2'b01);
    checks++; if (oce_s !== 2'b00) begin errs++; $display("FAIL other_addr_rd got %b exp 00", oce_s); end
  endtask

  task automatic test_conflict;
    @(negedge global_CLK);
    CS = 1'b0; A = 2'b00; control_word = 8'h77; WR = 1'b0; RD = 1'b0;
    #1;
    checks++; if ({out_count_enable, out_status_enable} !== 3'b000) begin errs++; $display("FAIL conflict_out got %b exp 000", {out_count_enable, out_status_enable}); end
    @(posedge global_CLK); #1;
    checks++; if (CR_enable !== 2'b01) begin errs++; $display("FAIL conflict_cre got %b exp 01", CR_enable); end
    @(negedge global_CLK);
    WR = 1'b1; RD = 1'b1; CS = 1'b1;
  endtask

  task automatic test_rw01;
    wr(2'b11, 8'h10);
    checks++; if (rw_mode !== 2'b01) begin errs++; $display("FAIL rw01_mode got %b exp 01", rw_mode); end
    @(negedge global_CLK);
    CS = 1'b0; A = 2'b00; control_word = 8'h55; WR = 1'b0;
    @(posedge global_CLK); #1;
    checks++; if ({CR_enable, load_new_count} !== 3'b011) begin errs++; $display("FAIL rw01_cre_lnc got %b exp 011", {CR_enable, load_new_count}); end
    @(negedge global_CLK);
    WR = 1'b1; CS = 1'b1; count_loaded = 1'b1;
    @(negedge global_CLK); count_loaded = 1'b0;
    checks++; if (null_count !== 1'b1) begin errs++; $display("FAIL rw01_null got %b exp 1", null_count); end
    rd(2'b00);
    checks++; if (oce_s !== 2'b01) begin errs++; $display("FAIL rw01_rd got %b exp 01", oce_s); end
  endtask

  task automatic test_readback;
    wr(2'b11, 8'h30);
    wr(2'b11, 8'hC2);
`ifdef COUNTER_READBACK_EN
    checks++; if (sle_s !== 1'b1) begin errs++; $display("FAIL rb_sle got %b exp 1", sle_s); end
    checks++; if (OL_enable !== 2'b00) begin errs++; $display("FAIL rb_ol got %b exp 00", OL_enable); end
    rd(2'b00);
    checks++; if ({ose_s, oce_s} !== 3'b100) begin errs++; $display("FAIL rb_rd1 got %b exp 100", {ose_s, oce_s}); end
    rd(2'b00);
    checks++; if ({ose_s, oce_s} !== 3'b001) begin errs++; $display("FAIL rb_rd2 got %b exp 001", {ose_s, oce_s}); end
    rd(2'b00);
    checks++; if ({ose_s, oce_s} !== 3'b010) begin errs++; $display("FAIL rb_rd3 got %b exp 010", {ose_s, oce_s}); end
    checks++; if (OL_enable !== 2'b11) begin errs++; $display("FAIL rb_ol_end got %b exp 11", OL_enable); end
`else
    checks++; if (sle_s !== 1'b0) begin errs++; $display("FAIL rb_sle got %b exp 0", sle_s); end
    checks++; if (OL_enable !== 2'b11) begin errs++; $display("FAIL rb_ol got %b exp 11", OL_enable); end
    rd(2'b00);
    checks++; if ({ose_s, oce_s} !== 3'b001) begin errs++; $display("FAIL rb_rd1 got %b exp 001", {ose_s, oce_s}); end
`endif
  endtask

  task automatic test_reset_abort;
    wr(2'b11, 8'h30);
    wr(2'b11, 8'h00);
    wr(2'b00, 8'h34);
    checks++; if (ci_s !== 1'b1) begin errs++; $display("FAIL abort_pre_ci got %b exp 1", ci_s); end
    @(negedge global_CLK); CR_reset = 1'b1;
    #1;
    checks++; if ({count_inhibit, rw_mode, OL_enable} !== 5'b00011) begin errs++; $display("FAIL abort_state got %b exp 00011", {count_inhibit, rw_mode, OL_enable}); end
    @(negedge global_CLK); CR_reset = 1'b0;
    wr(2'b00, 8'h99);
    checks++; if (cre_s !== 2'b00) begin errs++; $display("FAIL abort_post_cre got %b exp 00", cre_s); end
  endtask

  initial begin
    CR_reset = 1'b1; CS = 1'b1; WR = 1'b1; RD = 1'b1; A = 2'b00;
    control_word = 8'h00; count_loaded = 1'b0;
    test_reset;
    test_control_word;
    test_rw11_load;
    test_latch;
    test_conflict;
    test_rw01;
    test_readback;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
